// File: rtl/led_frame_scheduler_if.sv
// Pixel-memory read port and serializer pixel handshake between the frame
// scheduler (master) and the memory/serializer side (slave).
interface led_frame_scheduler_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd_en;
    logic [23:0]           mem_rdata;
    logic [23:0]           pixel_data;
    logic                  pixel_valid;
    logic                  pixel_ready;
    logic                  serializer_busy;

    modport master (
        output mem_addr,
        output mem_rd_en,
        input  mem_rdata,
        output pixel_data,
        output pixel_valid,
        input  pixel_ready,
        input  serializer_busy
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_en,
        output mem_rdata,
        input  pixel_data,
        input  pixel_valid,
        output pixel_ready,
        output serializer_busy
    );
endinterface

// File: rtl/led_frame_scheduler.sv
// Per-frame LED sequencer: fetches NUM_LEDS GRB words, scales them by a frame-wide
// brightness, hands them to the serializer, then holds the strip latch gap.
module led_frame_scheduler #(
    parameter int unsigned NUM_LEDS     = 60,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned LATCH_CYCLES = 960
) (
    input  logic                         clock_12mhz,
    input  logic                         reset,
    input  logic                         frame_tick,
    input  logic                         enable,
    input  logic [7:0]                   brightness,
    led_frame_scheduler_if.master        bus,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overrun,
    input  logic                         overrun_clear
);

    localparam int unsigned CNT_WIDTH = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0]  LATCH_LAST = CNT_WIDTH'(LATCH_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(NUM_LEDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StCapture,
        StSend,
        StDrain,
        StLatch
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic [7:0]            brt_q, brt_d;
    logic [23:0]           pixel_q, pixel_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  overrun_q, overrun_d;
    logic                  rd_en;

    // (c * (brt + 1)) >> 8; brt=255 is identity, brt=0 blanks the channel.
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] brt);
        logic [16:0] prod;
        prod = {9'd0, c} * ({9'd0, brt} + 17'd1);
        return 8'(prod >> 8);
    endfunction

    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            state_q   <= StIdle;
            index_q   <= '0;
            brt_q     <= '0;
            pixel_q   <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            brt_q     <= brt_d;
            pixel_q   <= pixel_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        brt_d      = brt_q;
        pixel_d    = pixel_q;
        cnt_d      = cnt_q;
        rd_en      = 1'b0;
        frame_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (frame_tick && enable) begin
                    brt_d   = brightness;
                    index_d = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                rd_en   = 1'b1;
                state_d = StCapture;
            end
            StCapture: begin
                pixel_d = {scale(bus.mem_rdata[23:16], brt_q),
                           scale(bus.mem_rdata[15:8], brt_q),
                           scale(bus.mem_rdata[7:0], brt_q)};
                state_d = StSend;
            end
            StSend: begin
                if (bus.pixel_ready) begin
                    if (index_q == LAST_INDEX) begin
                        state_d = StDrain;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            StDrain: begin
                if (!bus.serializer_busy) begin
                    cnt_d   = '0;
                    state_d = StLatch;
                end
            end
            StLatch: begin
                if (cnt_q == LATCH_LAST) begin
                    frame_done = 1'b1;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Set has priority over clear so a coincident dropped tick is never lost.
    always_comb begin
        overrun_d = overrun_q;
        if (overrun_clear) begin
            overrun_d = 1'b0;
        end
        if (frame_tick && busy) begin
            overrun_d = 1'b1;
        end
    end

    assign busy            = (state_q != StIdle);
    assign overrun         = overrun_q;
    assign bus.mem_addr    = index_q;
    assign bus.mem_rd_en   = rd_en;
    assign bus.pixel_data  = pixel_q;
    // Gated by reset so no pixel can be accepted while the frame is being abandoned.
    assign bus.pixel_valid = (state_q == StSend) && !reset;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench for led_frame_scheduler with a 4-LED frame and a 1-cycle-latency
// pixel memory model.
module tb_led_frame_scheduler;

    localparam int unsigned NUM_LEDS     = 4;
    localparam int unsigned ADDR_WIDTH   = 8;
    localparam int unsigned LATCH_CYCLES = 960;

    logic       clock_12mhz = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       enable;
    logic [7:0] brightness;
    logic       busy;
    logic       frame_done;
    logic       overrun;
    logic       overrun_clear;

    int total = 0;
    int bad   = 0;

    logic [23:0] mem [NUM_LEDS];

    led_frame_scheduler_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    led_frame_scheduler #(
        .NUM_LEDS    (NUM_LEDS),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .LATCH_CYCLES(LATCH_CYCLES)
    ) dut (
        .clock_12mhz  (clock_12mhz),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .enable       (enable),
        .brightness   (brightness),
        .bus          (bus),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun),
        .overrun_clear(overrun_clear)
    );

    always #5 clock_12mhz = ~clock_12mhz;

    always @(posedge clock_12mhz) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr[1:0]];
    end

    task automatic tick();
        @(posedge clock_12mhz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 3000 && busy; k++) tick();
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic load_pattern();
        for (int i = 0; i < NUM_LEDS; i++) mem[i] = 24'(24'h010203 * (i + 1));
    endtask

    initial begin
        int n;
        int extra;
        logic [23:0] exp_px;

        reset               = 1'b1;
        frame_tick          = 1'b0;
        enable              = 1'b0;
        brightness          = 8'd0;
        overrun_clear       = 1'b0;
        bus.pixel_ready     = 1'b1;
        bus.serializer_busy = 1'b0;
        bus.mem_rdata       = 24'd0;
        load_pattern();
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(bus.pixel_valid), 32'd0);
        check("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_data", 32'(bus.pixel_data), 32'd0);
        reset = 1'b0;

        // Full frame at identity brightness, ready tied high.
        enable              = 1'b1;
        brightness          = 8'd255;
        bus.serializer_busy = 1'b1;
        frame_tick          = 1'b1;
        tick();
        frame_tick = 1'b0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            exp_px = 24'(24'h010203 * (i + 1));
            check("fetch_rd_en", 32'(bus.mem_rd_en), 32'd1);
            check("fetch_addr", 32'(bus.mem_addr), 32'(i));
            check("fetch_valid", 32'(bus.pixel_valid), 32'd0);
            tick();
            check("capture_valid", 32'(bus.pixel_valid), 32'd0);
            tick();
            check("send_valid", 32'(bus.pixel_valid), 32'd1);
            check("send_data", 32'(bus.pixel_data), 32'(exp_px));
            tick();
        end
        check("drain_busy", 32'(busy), 32'd1);
        check("drain_valid", 32'(bus.pixel_valid), 32'd0);
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (frame_done) extra++;
        end
        check("drain_no_done", 32'(extra), 32'd0);
        bus.serializer_busy = 1'b0;
        n = 0;
        for (int k = 0; k < 1100; k++) begin
            tick();
            n++;
            if (frame_done) break;
        end
        check("latch_len", 32'(n), 32'(LATCH_CYCLES));
        tick();
        check("post_frame_busy", 32'(busy), 32'd0);
        check("post_frame_done", 32'(frame_done), 32'd0);

        // Scaling at 127; brightness change mid-frame must not apply.
        mem[0]     = 24'hFF8001;
        mem[1]     = 24'hFF8001;
        brightness = 8'd127;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        tick();
        check("scale_127", 32'(bus.pixel_data), 32'h7F4000);
        brightness = 8'd0;
        tick();
        tick();
        tick();
        check("scale_keep", 32'(bus.pixel_data), 32'h7F4000);
        wait_idle();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        tick();
        check("scale_0", 32'(bus.pixel_data), 32'h000000);
        wait_idle();
        load_pattern();

        // Backpressure with an overrun tick during SEND.
        brightness      = 8'd255;
        bus.pixel_ready = 1'b0;
        frame_tick      = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 10; k++) begin
            check("bp_valid", 32'(bus.pixel_valid), 32'd1);
            check("bp_data", 32'(bus.pixel_data), 32'h010203);
            check("bp_rd_en", 32'(bus.mem_rd_en), 32'd0);
            if (k == 4) frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
        end
        check("ovr_send", 32'(overrun), 32'd1);
        overrun_clear = 1'b1;
        tick();
        overrun_clear = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);
        check("bp_still_valid", 32'(bus.pixel_valid), 32'd1);
        bus.pixel_ready = 1'b1;
        tick();
        check("bp_resume_rd", 32'(bus.mem_rd_en), 32'd1);
        check("bp_resume_addr", 32'(bus.mem_addr), 32'd1);
        n = 0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (frame_done) begin
                n = 1;
                break;
            end
        end
        check("bp_done_seen", 32'(n), 32'd1);
        // Tick coincident with frame_done and with overrun_clear: dropped, set wins.
        frame_tick    = 1'b1;
        overrun_clear = 1'b1;
        tick();
        frame_tick    = 1'b0;
        overrun_clear = 1'b0;
        check("ovr_latch", 32'(overrun), 32'd1);
        check("latch_tick_dropped", 32'(busy), 32'd0);
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            if (frame_done || bus.mem_rd_en) extra++;
            tick();
        end
        check("single_done", 32'(extra), 32'd0);
        overrun_clear = 1'b1;
        tick();
        overrun_clear = 1'b0;
        check("ovr_clear2", 32'(overrun), 32'd0);

        // Reset while in SEND at index 2.
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("rst_mid_valid", 32'(bus.pixel_valid), 32'd1);
        check("rst_mid_addr", 32'(bus.mem_addr), 32'd2);
        check("rst_mid_data", 32'(bus.pixel_data), 32'h030609);
        reset = 1'b1;
        #1;
        check("rst_mid_valid_drop", 32'(bus.pixel_valid), 32'd0);
        tick();
        reset = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_valid2", 32'(bus.pixel_valid), 32'd0);
        check("rst_mid_addr0", 32'(bus.mem_addr), 32'd0);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        check("restart_rd", 32'(bus.mem_rd_en), 32'd1);
        check("restart_addr", 32'(bus.mem_addr), 32'd0);
        wait_idle();

        // Tick with enable low is ignored.
        enable     = 1'b0;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.mem_rd_en || busy) extra++;
            tick();
        end
        check("disabled_idle", 32'(extra), 32'd0);
        check("disabled_overrun", 32'(overrun), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_frame_scheduler.md
Name: led_frame_scheduler

Overview:
- Sequences one LED-strip frame per frame tick.
- Reads NUM_LEDS 24-bit GRB words from pixel memory and applies a global brightness scale.
- Hands each pixel to the bit serializer over a valid/ready handshake, then enforces the strip latch (reset) gap.
- Sits between the clock generator's frame-rate strobe and the serializer; it is the only master of pixel-memory reads.

Parameters:
- NUM_LEDS, 60, number of LEDs per frame (1..2**ADDR_WIDTH).
- ADDR_WIDTH, 8, pixel memory address width.
- LATCH_CYCLES, 960, clock_12mhz cycles of line-low latch after the last bit (80 us).

Ports:
- clock_12mhz  in  1  system clock, 12 MHz.
- reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse requesting a frame.
- enable  in  1  frames start only while high.
- brightness  in  8  global scale, sampled at frame start.
- mem_addr  out  ADDR_WIDTH  pixel read address.
- mem_rd_en  out  1  read strobe; mem_rdata is valid exactly 1 cycle later.
- mem_rdata  in  24  GRB word, G in [23:16], R in [15:8], B in [7:0].
- pixel_data  out  24  scaled GRB word to the serializer.
- pixel_valid  out  1  pixel_data valid.
- pixel_ready  in  1  serializer accepts the pixel.
- serializer_busy  in  1  serializer still shifting bits.
- busy  out  1  frame in progress (any state except IDLE).
- frame_done  out  1  one-cycle pulse at the end of latch.
- overrun  out  1  sticky: a frame_tick arrived while busy.
- overrun_clear  in  1  clears overrun.

Behaviour:
- Reset values: all outputs 0; state IDLE; LED index 0; latch counter 0.
- Reset mid-frame returns to IDLE on the next edge. pixel_valid drops immediately and the current frame is abandoned.
- States:
  - IDLE: on frame_tick && enable, capture brightness into brt_q, set index 0, go to FETCH. frame_tick with enable low is ignored, with no overrun.
  - FETCH (1 cycle): mem_rd_en=1, mem_addr=index; go to CAPTURE.
  - CAPTURE (1 cycle): register the scaled mem_rdata into pixel_data; go to SEND.
  - SEND: pixel_valid=1; pixel_data is held stable until the handshake completes.
    - On pixel_valid && pixel_ready with index==NUM_LEDS-1: go to DRAIN.
    - On the handshake otherwise: index+1, go to FETCH.
  - DRAIN: wait for serializer_busy==0, then clear the latch counter and go to LATCH.
  - LATCH: count up to LATCH_CYCLES-1. At terminal count, pulse frame_done for 1 cycle and go to IDLE.
- Latency:
  - frame_tick to first pixel_valid: 3 cycles.
  - Handshake to next pixel_valid: 3 cycles.
  - pixel_valid is deasserted during FETCH and CAPTURE.
- Scaling, per 8-bit channel c: out = (c * (brt_q + 1)) >> 8, with a 17-bit intermediate truncated to 8 bits.
  - brt_q=255 gives identity; brt_q=0 gives c>>8, i.e. 0 for all c.
  - brt_q is constant for the whole frame; brightness changes mid-frame take effect next frame.
- Overrun:
  - frame_tick while busy=1 sets overrun and the tick is dropped (no queueing).
  - overrun_clear clears overrun. If clear and a new overrun tick coincide in the same cycle, set wins.
- frame_tick in the same cycle as frame_done is an overrun. The FSM is still in LATCH, so the tick is dropped.
- Index wraps only via frame restart; mem_addr never exceeds NUM_LEDS-1.
- pixel_ready outside SEND is ignored.
- enable falling mid-frame does not abort; the frame completes.

Test Plan:
- NUM_LEDS=4, brightness=255, memory[i]=24'h010203*(i+1), pixel_ready tied 1:
  - Four pixels arrive in address order with exact values.
  - pixel_valid high 1 cycle each, spaced 3 cycles apart.
  - After serializer_busy falls, frame_done pulses exactly 960 cycles later.
- brightness=127, rdata=24'hFF8001 -> pixel_data=24'h7F4000. brightness=0 -> 24'h000000.
- Backpressure: pixel_ready low for 10 cycles in SEND -> pixel_valid and pixel_data are held stable and mem_rd_en stays 0; the frame proceeds on ready.
- frame_tick during SEND and another during LATCH -> overrun=1, exactly one frame_done. overrun_clear together with a new busy tick -> overrun stays 1.
- Reset asserted in SEND at index 2 -> the next cycle shows busy=0, pixel_valid=0, mem_addr=0; a new frame_tick restarts from index 0.
- frame_tick with enable=0 -> no mem_rd_en, overrun stays 0; brightness changed mid-frame -> remaining pixels use the original scale.
